seq_restoring_divider: RTL and testbench

- Iterative unsigned restoring divider; the inverse of the team's array multipliers. Recovers the quotient and remainder from a product-width operand.
- Computes one quotient bit per clock behind a start/done handshake.
- Sits beside the multiplier blocks; used to check and undo multiplication results in datapath tests.

---
 rtl/divider_pkg.sv | 19 +
 rtl/div_step.sv | 24 ++
 rtl/seq_restoring_divider.sv | 131 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding,
// default operand widths and the iteration-counter width helper.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DVD_W_DEF = 7;
   localparam int DVR_W_DEF = 4;

   // Counter must be able to hold DVD_W itself (it reaches DVD_W on the last step).
   function automatic int cnt_w(input int dvd_w);
      return $clog2(dvd_w + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module div_step #(
   parameter int DVR_W = 4
) (
   input  logic [DVR_W:0]   prem,
   input  logic             dvd_msb,
   input  logic [DVR_W-1:0] divisor,
   output logic [DVR_W:0]   prem_nxt,
   output logic             q_bit
);

   logic [DVR_W+1:0] diff;

   // prem is always < divisor after a restore, so its top bit is zero and the
   // wider subtraction gives the same borrow as the DVR_W+1 bit trial.
   always_comb begin
      diff  = {prem, dvd_msb} - {2'b00, divisor};
      q_bit = ~diff[DVR_W+1];
      if (q_bit) prem_nxt = diff[DVR_W:0];
      else       prem_nxt = {prem[DVR_W-1:0], dvd_msb};
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock behind a
// start/done handshake. Divide-by-zero short-circuits to an all-ones quotient.
// Optional macro DIVIDER_SELFCHECK_EN adds a quotient*divisor+remainder check
// reported on chk_err; without it chk_err is tied low.
module seq_restoring_divider
   import divider_pkg::*;
#(
   parameter int DVD_W = DVD_W_DEF,
   parameter int DVR_W = DVR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVR_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient,
   output logic [DVR_W-1:0] remainder,
   output logic             dbz,
   output logic             chk_err
);

   localparam int CW = cnt_w(DVD_W);

   div_state_t       state;
   logic [DVD_W-1:0] dvd_sh;
   logic [DVR_W-1:0] dvr;
   logic [DVR_W:0]   prem;
   logic [DVR_W:0]   prem_nxt;
   logic             q_bit;
   logic [CW-1:0]    cnt;
   logic             last;
   logic [DVD_W-1:0] q_nxt;

   div_step #(.DVR_W(DVR_W)) u_step (
      .prem     (prem),
      .dvd_msb  (dvd_sh[DVD_W-1]),
      .divisor  (dvr),
      .prem_nxt (prem_nxt),
      .q_bit    (q_bit)
   );

   assign last  = (cnt == CW'(DVD_W - 1));
   assign q_nxt = {quotient[DVD_W-2:0], q_bit};

   // Control FSM and datapath registers; the quotient register doubles as the
   // shift register that collects quotient bits during RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         dbz       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         cnt       <= '0;
         dvd_sh    <= '0;
         dvr       <= '0;
         prem      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (divisor != '0) begin
                     state    <= RUN;
                     dvd_sh   <= dividend;
                     dvr      <= divisor;
                     prem     <= '0;
                     quotient <= '0;
                     cnt      <= '0;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     dbz      <= 1'b0;
                  end else begin
                     state     <= DONE;
                     quotient  <= '1;
                     remainder <= dividend[DVR_W-1:0];
                     dbz       <= 1'b1;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
            end
            RUN: begin
               prem     <= prem_nxt;
               dvd_sh   <= {dvd_sh[DVD_W-2:0], 1'b0};
               quotient <= q_nxt;
               cnt      <= cnt + CW'(1);
               if (last) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  dbz       <= 1'b0;
                  remainder <= prem_nxt[DVR_W-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DIVIDER_SELFCHECK_EN
   logic                   accept;
   logic [DVD_W-1:0]       dvd_lat;
   logic                   chk_q;
   logic [DVD_W+DVR_W-1:0] recon;

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign recon  = ({{DVR_W{1'b0}}, q_nxt} * {{DVD_W{1'b0}}, dvr})
                 + {{DVD_W{1'b0}}, prem_nxt[DVR_W-1:0]};

   // Keep the original dividend and compare the reconstruction as the last step retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_lat <= '0;
         chk_q   <= 1'b0;
      end else if (accept) begin
         dvd_lat <= dividend;
         chk_q   <= 1'b0;
      end else if ((state == RUN) && last) begin
         chk_q   <= (recon != {{DVR_W{1'b0}}, dvd_lat});
      end
   end

   assign chk_err = chk_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vector table,
// multi-cycle corner sequences and randomized operations against a plain
// arithmetic reference model.
module tb_seq_restoring_divider;

   localparam int DVD_W = 7;
   localparam int DVR_W = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [DVD_W-1:0] dividend;
   logic [DVR_W-1:0] divisor;
   logic             busy;
   logic             done;
   logic [DVD_W-1:0] quotient;
   logic [DVR_W-1:0] remainder;
   logic             dbz;
   logic             chk_err;

   int checks = 0;
   int errors = 0;

   seq_restoring_divider #(.DVD_W(DVD_W), .DVR_W(DVR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .chk_err   (chk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DVD_W-1:0] a;
      logic [DVR_W-1:0] b;
      logic [DVD_W-1:0] q;
      logic [DVR_W-1:0] r;
      logic             z;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // busy and done must never be high together
   always @(negedge clk) begin
      if (rst_n) chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
   end

   // Issue one operation; optionally pulse a rogue start at RUN cycle poke_at.
   task automatic run_op(input logic [DVD_W-1:0] a, input logic [DVR_W-1:0] b,
                         input logic [DVD_W-1:0] eq, input logic [DVR_W-1:0] er,
                         input logic ez, input int poke_at, input string nm);
      int   lat;
      logic saw_busy;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      saw_busy = busy;
      while (!done && lat < 40) begin
         if (lat == poke_at) begin
            start = 1'b1; dividend = 7'd100; divisor = 4'd3;
         end else begin
            start = 1'b0; dividend = DVD_W'($urandom); divisor = DVR_W'($urandom);
         end
         @(negedge clk);
         lat++;
         saw_busy |= busy;
      end
      start = 1'b0;
      chk({nm, "_latency"}, lat, ez ? 32'd0 : 32'd7);
      chk({nm, "_done"}, {31'd0, done}, 32'd1);
      chk({nm, "_quot"}, {25'd0, quotient}, {25'd0, eq});
      chk({nm, "_rem"}, {28'd0, remainder}, {28'd0, er});
      chk({nm, "_dbz"}, {31'd0, dbz}, {31'd0, ez});
      chk({nm, "_chk_err"}, {31'd0, chk_err}, 32'd0);
      if (ez) chk({nm, "_no_busy"}, {31'd0, saw_busy}, 32'd0);
   endtask

   // Reference model: plain integer division with the zero-divisor convention.
   function automatic logic [DVD_W-1:0] ref_q(input int a, input int b);
      return (b == 0) ? DVD_W'(127) : DVD_W'(a / b);
   endfunction
   function automatic logic [DVR_W-1:0] ref_r(input int a, input int b);
      return (b == 0) ? DVR_W'(a % 16) : DVR_W'(a % b);
   endfunction

   initial begin
      vecs[0] = '{a: 7'd93,  b: 4'd7,  q: 7'd13,  r: 4'd2,  z: 1'b0};
      vecs[1] = '{a: 7'd127, b: 4'd15, q: 7'd8,   r: 4'd7,  z: 1'b0};
      vecs[2] = '{a: 7'd127, b: 4'd1,  q: 7'd127, r: 4'd0,  z: 1'b0};
      vecs[3] = '{a: 7'd5,   b: 4'd0,  q: 7'd127, r: 4'd5,  z: 1'b1};
      vecs[4] = '{a: 7'd0,   b: 4'd5,  q: 7'd0,   r: 4'd0,  z: 1'b0};
      vecs[5] = '{a: 7'd50,  b: 4'd6,  q: 7'd8,   r: 4'd2,  z: 1'b0};
      vecs[6] = '{a: 7'd126, b: 4'd0,  q: 7'd127, r: 4'd14, z: 1'b1};
      vecs[7] = '{a: 7'd64,  b: 4'd9,  q: 7'd7,   r: 4'd1,  z: 1'b0};

      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dbz", {31'd0, dbz}, 32'd0);
      chk("rst_chk_err", {31'd0, chk_err}, 32'd0);
      chk("rst_quot", {25'd0, quotient}, 32'd0);
      chk("rst_rem", {28'd0, remainder}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed table; each op starts while the previous result is held in DONE
      for (int i = 0; i < 8; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, -1,
                $sformatf("vec%0d", i));

      // Results held in DONE
      repeat (3) @(negedge clk);
      chk("hold_done", {31'd0, done}, 32'd1);
      chk("hold_quot", {25'd0, quotient}, 32'd7);
      chk("hold_rem", {28'd0, remainder}, 32'd1);

      // Start during RUN is ignored
      run_op(7'd12, 4'd5, 7'd2, 4'd2, 1'b0, 2, "ignore_start");

      // Back-to-back: 0/5 accepted straight from DONE, done must drop next cycle
      @(negedge clk);
      start = 1'b1; dividend = 7'd0; divisor = 4'd5;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_done_drop", {31'd0, done}, 32'd0);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      repeat (6) @(negedge clk);
      chk("b2b_still_busy", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("b2b_done", {31'd0, done}, 32'd1);
      chk("b2b_quot", {25'd0, quotient}, 32'd0);
      chk("b2b_rem", {28'd0, remainder}, 32'd0);

      // Reset in the middle of 93/7
      @(negedge clk);
      start = 1'b1; dividend = 7'd93; divisor = 4'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      chk("mrst_quot", {25'd0, quotient}, 32'd0);
      chk("mrst_rem", {28'd0, remainder}, 32'd0);
      chk("mrst_dbz", {31'd0, dbz}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("mrst_no_done", {31'd0, done | busy}, 32'd0);
      run_op(7'd50, 4'd6, 7'd8, 4'd2, 1'b0, -1, "after_rst");

      // Randomized operations against the reference model
      for (int i = 0; i < 60; i++) begin
         int a, b;
         a = int'($urandom_range(0, 127));
         b = (i % 10 == 0) ? 0 : int'($urandom_range(0, 15));
         run_op(DVD_W'(a), DVR_W'(b), ref_q(a, b), ref_r(a, b), (b == 0), -1,
                $sformatf("rnd%0d_%0d_%0d", i, a, b));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
